// File: rtl/vga_pattern_gen.sv
// VGA timing and four-mode test-pattern generator. Outputs are registered one pix_en edge
// behind the hc/vc raster counters; mode changes take effect only at pixel (0,0).
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned BAR_W     = 80,
  parameter int unsigned TILE_LOG2 = 3,
  parameter int unsigned FRAME_DIV = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [1:0]         mode_in,
  input  logic               mode_load,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start,
  output logic [1:0]         mode_cur
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HLast     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActive   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BarW      = CNT_W'(BAR_W);
  localparam int unsigned      FcW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FcW-1:0]   FcLast    = FcW'(FRAME_DIV - 1);
  localparam logic [1:0]       ModeCycle = 2'd3;

  logic [CNT_W-1:0]   hc_q, hc_d, vc_q, vc_d;
  logic [1:0]         mode_pend_q, mode_pend_d, mode_q, mode_d;
  logic [FcW-1:0]     fc_q, fc_d;
  logic [2:0]         col_q, col_d;
  logic               boundary, active, hsync_act, vsync_act;
  logic [2:0]         bar_sel, c;
  logic               tile_bit;
  logic               hs_q, vs_q, de_q, frame_start_q;
  logic [CNT_W-1:0]   x_q, y_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  assign boundary = pix_en && (hc_q == '0) && (vc_q == '0);

  // Raster counters and mode/colour-cycle state
  always_comb begin
    hc_d        = hc_q;
    vc_d        = vc_q;
    mode_pend_d = mode_load ? mode_in : mode_pend_q;
    mode_d      = mode_q;
    fc_d        = fc_q;
    col_d       = col_q;
    if (pix_en) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
    if (boundary) begin
      mode_d = mode_load ? mode_in : mode_pend_q;
      if (mode_d == ModeCycle) begin
        if (mode_q != ModeCycle) begin
          fc_d  = '0;
          col_d = '0;
        end else if (fc_q == FcLast) begin
          fc_d  = '0;
          col_d = col_q + 3'd1;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
    end
  end

  // Pixel colour uses the next mode/colour so a switch lands on the frame_start pixel itself
  always_comb begin
    active    = (hc_q < HActive) && (vc_q < VActive);
    hsync_act = (hc_q >= HSyncBeg) && (hc_q < HSyncEnd);
    vsync_act = (vc_q >= VSyncBeg) && (vc_q < VSyncEnd);
    bar_sel   = 3'(hc_q / BarW);
    tile_bit  = 1'((hc_q >> TILE_LOG2) ^ (vc_q >> TILE_LOG2));
    case (mode_d)
      2'd0:    c = 3'b111;
      2'd1:    c = 3'd7 - bar_sel;
      2'd2:    c = {3{tile_bit}};
      default: c = col_d;
    endcase
    if (!active) begin
      c = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= '0;
      vc_q          <= '0;
      mode_pend_q   <= '0;
      mode_q        <= '0;
      fc_q          <= '0;
      col_q         <= '0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mode_pend_q   <= mode_pend_d;
      mode_q        <= mode_d;
      fc_q          <= fc_d;
      col_q         <= col_d;
      frame_start_q <= boundary;
      if (pix_en) begin
        x_q  <= hc_q;
        y_q  <= vc_q;
        de_q <= active;
        hs_q <= ~hsync_act;
        vs_q <= ~vsync_act;
        // c is {g, r, b}
        r_q  <= {COLOR_W{c[1]}};
        g_q  <= {COLOR_W{c[2]}};
        b_q  <= {COLOR_W{c[0]}};
      end
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = frame_start_q;
  assign mode_cur    = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken raster; a frame-position model predicts every output.
module tb_vga_pattern_gen;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 12, VF = 1, VSW = 2, VB = 2;
  localparam int CW = 8, NW = 6, BW = 2, TL = 1, FD = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst, pix_en, mode_load;
  logic [1:0]    mode_in;
  logic          hs, vs, de, frame_start;
  logic [NW-1:0] x, y;
  logic [CW-1:0] r, g, b;
  logic [1:0]    mode_cur;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .COLOR_W(CW), .CNT_W(NW), .BAR_W(BW), .TILE_LOG2(TL), .FRAME_DIV(FD)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode_in(mode_in), .mode_load(mode_load),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .r(r), .g(g), .b(b),
    .frame_start(frame_start), .mode_cur(mode_cur)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: linear pixel position within the frame plus mode/colour bookkeeping
  int            pos;
  logic [1:0]    m_pend, m_cur;
  int            m_fc, m_col;
  logic          e_fs, e_hs, e_vs, e_de;
  logic [NW-1:0] e_x, e_y;
  logic [2:0]    e_c;

  function automatic logic [2:0] colour(input logic [1:0] m, input int col, input int xx,
                                        input int yy);
    case (m)
      2'd0:    return 3'd7;
      2'd1:    return 3'(7 - (xx / BW) % 8);
      2'd2:    return ((((xx >> TL) ^ (yy >> TL)) & 1) != 0) ? 3'd7 : 3'd0;
      default: return 3'(col);
    endcase
  endfunction

  task automatic model_step(input logic r_i, input logic pe_i, input logic ml_i,
                            input logic [1:0] mi_i);
    int hh, vv;
    logic [1:0] nm;
    if (r_i) begin
      pos = 0; m_pend = 0; m_cur = 0; m_fc = 0; m_col = 0;
      e_fs = 0; e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_c = 0;
      return;
    end
    e_fs = pe_i && (pos == 0);
    if (pe_i) begin
      hh = pos % HT;
      vv = pos / HT;
      if (pos == 0) begin
        nm = ml_i ? mi_i : m_pend;
        if (nm == 2'd3) begin
          if (m_cur != 2'd3) begin
            m_fc = 0; m_col = 0;
          end else begin
            m_fc++;
            if (m_fc == FD) begin
              m_fc = 0; m_col = (m_col + 1) % 8;
            end
          end
        end
        m_cur = nm;
      end
      e_x  = NW'(hh);
      e_y  = NW'(vv);
      e_de = (hh < HA) && (vv < VA);
      e_hs = !((hh >= HA + HF) && (hh < HA + HF + HSW));
      e_vs = !((vv >= VA + VF) && (vv < VA + VF + VSW));
      e_c  = e_de ? colour(m_cur, m_col, hh, vv) : 3'd0;
      pos  = (pos + 1) % FRAME;
    end
    if (ml_i) m_pend = mi_i;
  endtask

  task automatic cycle(input logic r_i, input logic pe_i, input logic ml_i,
                       input logic [1:0] mi_i);
    logic [3*CW-1:0] e_rgb;
    @(negedge clk);
    rst = r_i; pix_en = pe_i; mode_load = ml_i; mode_in = mi_i;
    model_step(r_i, pe_i, ml_i, mi_i);
    @(posedge clk);
    #1;
    cyc++;
    e_rgb = {{CW{e_c[1]}}, {CW{e_c[2]}}, {CW{e_c[0]}}};
    check("timing", {frame_start, hs, vs, de, x, y, mode_cur},
          {e_fs, e_hs, e_vs, e_de, e_x, e_y, m_cur});
    check("rgb", {r, g, b}, e_rgb);
    if (mode_cur == 2'd1 && de && x == NW'(BW) && y == '0)
      check("bar_c6", {r, g, b}, 24'hFFFF00);
    if (mode_cur == 2'd2 && de && x == NW'(1 << TL) && y == '0)
      check("tile_white", {r, g, b}, 24'hFFFFFF);
    if (mode_cur == 2'd2 && de && x == NW'(1 << TL) && y == NW'(1 << TL))
      check("tile_black", {r, g, b}, 24'h000000);
  endtask

  initial begin
    int fs_cnt, de_cnt, hs_lo, vs_lo, first_vs_y;
    int fs_t[$];
    bit loaded, armed;
    rst = 1'b1; pix_en = 1'b0; mode_load = 1'b0; mode_in = 2'd0;

    // Reset state
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'd0);
    check("reset", {hs, vs, de, frame_start, mode_cur, x, y, r, g, b},
          {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, {NW{1'b0}}, {NW{1'b0}}, {3*CW{1'b0}}});

    // Continuous pix_en in mode 0: frame rhythm and sync widths
    fs_cnt = 0; de_cnt = 0; hs_lo = 0; vs_lo = 0; first_vs_y = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'd0);
      if (i == 0) check("first_pixel", {frame_start, de, x, y}, {1'b1, 1'b1, 12'd0});
      if (frame_start) begin fs_cnt++; fs_t.push_back(cyc); end
      if (de) de_cnt++;
      if (!hs) hs_lo++;
      if (!vs) begin vs_lo++; if (first_vs_y < 0) first_vs_y = int'(y); end
    end
    check("fs_count", 64'(fs_cnt), 64'd2);
    check("de_count", 64'(de_cnt), 64'(2 * HA * VA));
    check("hs_low", 64'(hs_lo), 64'(2 * HSW * VT));
    check("vs_low", 64'(vs_lo), 64'(2 * VSW * HT));
    check("vs_start_y", 64'(first_vs_y), 64'(VA + VF));
    if (fs_t.size() >= 2) check("frame_period", 64'(fs_t[1] - fs_t[0]), 64'(FRAME));
    else check("frame_period_seen", 64'(fs_t.size()), 64'd2);

    // Mode 1 loaded mid-frame, then mode 2
    repeat (100) cycle(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 2'd1);
    check("mode_hold", 64'(mode_cur), 64'd0);
    repeat (FRAME + 50) cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check("mode1_live", 64'(mode_cur), 64'd1);
    cycle(1'b0, 1'b1, 1'b1, 2'd2);
    repeat (FRAME + 50) cycle(1'b0, 1'b1, 1'b0, 2'd0);

    // Mode 3 colour cycling through a full wrap
    cycle(1'b0, 1'b1, 1'b1, 2'd3);
    repeat ((8 * FD + 2) * FRAME) cycle(1'b0, 1'b1, 1'b0, 2'd0);

    // Half-rate pix_en with a load on the frame_start clk
    fs_t.delete();
    loaded = 0; armed = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      if ((i % 2) == 1 && pos == 0 && !loaded) begin
        loaded = 1; armed = 1;
        cycle(1'b0, 1'b1, 1'b1, 2'd2);
      end else begin
        cycle(1'b0, 1'((i % 2) == 1), 1'b0, 2'd0);
      end
      if (armed) begin
        check("load_on_fs", {frame_start, mode_cur}, {1'b1, 2'd2});
        armed = 0;
      end
      if (frame_start) fs_t.push_back(cyc);
    end
    if (fs_t.size() >= 2) check("half_rate_period", 64'(fs_t[1] - fs_t[0]), 64'(2 * FRAME));
    else check("half_rate_fs_seen", 64'(fs_t.size()), 64'd2);

    // Reset mid-frame
    for (int i = 0; i < FRAME && pos != 5 * HT + 7; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check("rst_point", 64'(pos), 64'(5 * HT + 7));
    cycle(1'b1, 1'b1, 1'b0, 2'd0);
    check("rst_mid", {de, hs, vs, mode_cur}, {1'b0, 1'b1, 1'b1, 2'd0});
    cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check("restart", {frame_start, x, y}, {1'b1, 12'd0});

    // Randomised traffic
    for (int i = 0; i < 8000; i++) begin
      cycle(1'($urandom_range(0, 2999) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
